// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit
//   RV32M/RV64M multiply/divide unit that sits beside the integer ALU in EX.
//   The multiply path is a fixed-latency staged multiplier. The divide path is
//   an iterative restoring divider that resolves one quotient bit per cycle.
//   Only one operation is in flight at a time. Issue is stalled through
//   IN_READY, which is high only while the unit is idle.
//
// Ports
//   CLK, RESET_N         rising-edge clock, asynchronous active-low reset
//   IN_VALID/IN_READY    request handshake; FUNCT3, DATA1, DATA2 and IN_TAG
//                        are captured on accept
//   KILL                 synchronous flush of the in-flight or unread op
//   OUT_VALID/OUT_READY  result handshake; RESULT and OUT_TAG are held
//                        stable until the result is accepted
//   BUSY                 high whenever the unit is not idle
module rv_muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int TAG_W      = 5
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [2:0]       FUNCT3,
    input  logic [XLEN-1:0]  DATA1,
    input  logic [XLEN-1:0]  DATA2,
    input  logic [TAG_W-1:0] IN_TAG,
    input  logic             KILL,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  RESULT,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             BUSY
);

    localparam int CNT_MAX = (XLEN > MUL_STAGES) ? XLEN : MUL_STAGES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'((MUL_STAGES > 1) ? MUL_STAGES - 2 : 0);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;

    // Two's-complement negate when requested; used for magnitudes and sign fixup.
    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // MUL takes the low half of the product; MULH/MULHSU/MULHU take the high half.
    function automatic logic [XLEN-1:0] mul_select(input logic [2*XLEN-1:0] p, input logic [1:0] f);
        return (f == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    // Request decode
    logic            accept, is_div, div_signed, is_rem, div_zero, div_ovf, special;
    logic [XLEN-1:0] special_val;

    assign IN_READY   = (state == S_IDLE);
    assign BUSY       = (state != S_IDLE);
    assign OUT_VALID  = (state == S_DONE);
    assign accept     = IN_VALID && IN_READY && !KILL;
    assign is_div     = FUNCT3[2];
    assign div_signed = ~FUNCT3[0];
    assign is_rem     = FUNCT3[1];
    assign div_zero   = (DATA2 == '0);
    assign div_ovf    = div_signed && (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == '1);
    assign special    = is_div && (div_zero || div_ovf);

    // Divide-by-zero takes precedence: it also covers a signed zero divisor.
    always_comb begin
        special_val = '0;
        if (div_zero) special_val = is_rem ? DATA1 : '1;
        else          special_val = is_rem ? '0 : DATA1;
    end

    // Operands are widened to 2*XLEN so that the truncated product is the full
    // signed/unsigned product. rs1 is signed for all but MULHU; rs2 is signed
    // only for MUL/MULH.
    logic                     mul_a_sgn, mul_b_sgn;
    logic signed [2*XLEN-1:0] mul_a, mul_b, mul_full;

    assign mul_a_sgn = (FUNCT3[1:0] != 2'b11);
    assign mul_b_sgn = ~FUNCT3[1];
    assign mul_a     = {{XLEN{mul_a_sgn & DATA1[XLEN-1]}}, DATA1};
    assign mul_b     = {{XLEN{mul_b_sgn & DATA2[XLEN-1]}}, DATA2};
    assign mul_full  = mul_a * mul_b;

    // Operation state and restoring-divider registers
    logic [1:0]               op_p0;
    logic signed [2*XLEN-1:0] prod_p0;
    logic [XLEN-1:0]          quo_p1, rem_p1, dsr_p1;
    logic                     neg_q_p1, neg_r_p1;

    // The trial subtraction fits in XLEN bits whenever it is taken, because
    // the partial remainder is always below the divisor.
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] rem_next, div_result;
    logic            rem_fits;

    assign rem_sh     = {rem_p1, quo_p1[XLEN-1]};
    assign rem_fits   = (rem_sh >= {1'b0, dsr_p1});
    assign rem_next   = rem_sh[XLEN-1:0] - dsr_p1;
    assign div_result = op_p0[1] ? cond_neg(rem_p1, neg_r_p1) : cond_neg(quo_p1, neg_q_p1);

    // Stage p0/p1: capture on accept (includes divide magnitude setup), then iterate
    always_ff @(posedge CLK) begin
        if (accept) begin
            op_p0    <= FUNCT3[1:0];
            prod_p0  <= mul_full;
            quo_p1   <= cond_neg(DATA1, div_signed & DATA1[XLEN-1]);
            dsr_p1   <= cond_neg(DATA2, div_signed & DATA2[XLEN-1]);
            rem_p1   <= '0;
            neg_q_p1 <= div_signed & (DATA1[XLEN-1] ^ DATA2[XLEN-1]);
            neg_r_p1 <= div_signed & DATA1[XLEN-1];
        end else if (state == S_DIV && cnt < DIV_LAST) begin
            quo_p1 <= {quo_p1[XLEN-2:0], rem_fits};
            rem_p1 <= rem_fits ? rem_next : rem_sh[XLEN-1:0];
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (!is_div)      state_nxt = (MUL_STAGES == 1) ? S_DONE : S_MUL;
                    else if (special) state_nxt = S_DONE;
                    else              state_nxt = S_DIV;
                end
            end
            S_MUL:   if (cnt == MUL_LAST) state_nxt = S_DONE;
            S_DIV:   if (cnt == DIV_LAST) state_nxt = S_DONE;
            S_DONE:  if (OUT_READY) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (KILL) state_nxt = S_IDLE;
    end

    // Control and output registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= S_IDLE;
            cnt     <= '0;
            RESULT  <= '0;
            OUT_TAG <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == state && (state == S_MUL || state == S_DIV))
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            if (accept) OUT_TAG <= IN_TAG;
            if (accept && special)
                RESULT <= special_val;
            else if (accept && !is_div && MUL_STAGES == 1)
                RESULT <= mul_select(mul_full, FUNCT3[1:0]);
            else if (state == S_MUL && state_nxt == S_DONE)
                RESULT <= mul_select(prod_p0, op_p0);
            else if (state == S_DIV && state_nxt == S_DONE)
                RESULT <= div_result;
        end
    end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
module tb_rv_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [2:0]  FUNCT3 = 3'd0;
    logic [31:0] DATA1 = 32'd0;
    logic [31:0] DATA2 = 32'd0;
    logic [4:0]  IN_TAG = 5'd0;
    logic        KILL = 1'b0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [31:0] RESULT;
    logic [4:0]  OUT_TAG;
    logic        BUSY;

    int checks = 0;
    int failures = 0;

    rv_muldiv_unit #(.XLEN(32), .MUL_STAGES(2), .TAG_W(5)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .FUNCT3(FUNCT3), .DATA1(DATA1), .DATA2(DATA2), .IN_TAG(IN_TAG), .KILL(KILL),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .RESULT(RESULT),
        .OUT_TAG(OUT_TAG), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Presents one request for exactly one edge (the accept edge).
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        IN_VALID = 1'b1; FUNCT3 = f; DATA1 = a; DATA2 = b; IN_TAG = tag;
        step();
        IN_VALID = 1'b0;
    endtask

    // Latency counted in edges, the accept edge being edge 1; bounded.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!OUT_VALID && lat < 200) begin
            step();
            lat++;
        end
    endtask

    task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(f, a, b, tag);
        wait_valid(lat);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " result"}, RESULT, exp);
        check({name, " tag"}, OUT_TAG, tag);
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        check({name, " release rdy/vld/busy"}, {IN_READY, OUT_VALID, BUSY}, 3'b100);
    endtask

    initial begin
        int lat;
        bit seen;

        // Reset state
        step(); step();
        check("reset vld/busy", {OUT_VALID, BUSY}, 2'b00);
        check("reset result", RESULT, 32'd0);
        check("reset tag", OUT_TAG, 5'd0);
        RESET_N = 1'b1;
        step();
        check("reset in_ready", IN_READY, 1'b1);

        // Multiply
        do_op("MULHU ff*ff",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 2);
        do_op("MUL ff*ff",    3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000001, 2);
        do_op("MULHSU -1*2",  3'd2, 32'hFFFFFFFF, 32'h00000002, 5'd3,  32'hFFFFFFFF, 2);
        do_op("MULH -1*2",    3'd1, 32'hFFFFFFFF, 32'h00000002, 5'd4,  32'hFFFFFFFF, 2);
        do_op("MULHU ff*2",   3'd3, 32'hFFFFFFFF, 32'h00000002, 5'd5,  32'h00000001, 2);
        do_op("MULH min*min", 3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 2);
        do_op("MUL low",      3'd0, 32'h12345678, 32'h00000010, 5'd7,  32'h23456780, 2);
        do_op("MULHSU 2*ff",  3'd2, 32'h00000002, 32'hFFFFFFFF, 5'd8,  32'h00000001, 2);

        // Iterative divide
        do_op("DIV -7/2",     3'd4, 32'hFFFFFFF9, 32'h00000002, 5'd9,  32'hFFFFFFFD, 34);
        do_op("REM -7/2",     3'd6, 32'hFFFFFFF9, 32'h00000002, 5'd10, 32'hFFFFFFFF, 34);
        do_op("DIVU 100/7",   3'd5, 32'd100,      32'd7,        5'd11, 32'd14,       34);
        do_op("REMU 100/7",   3'd7, 32'd100,      32'd7,        5'd12, 32'd2,        34);
        do_op("DIV 7/-2",     3'd4, 32'd7,        32'hFFFFFFFE, 5'd13, 32'hFFFFFFFD, 34);
        do_op("REM 7/-2",     3'd6, 32'd7,        32'hFFFFFFFE, 5'd14, 32'd1,        34);
        do_op("DIVU min/ff",  3'd5, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        34);
        do_op("REMU min/ff",  3'd7, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 34);

        // Special cases resolved at accept
        do_op("DIV x/0",      3'd4, 32'h00001234, 32'd0,        5'd17, 32'hFFFFFFFF, 1);
        do_op("REM 5/0",      3'd6, 32'd5,        32'd0,        5'd18, 32'd5,        1);
        do_op("DIVU 9/0",     3'd5, 32'd9,        32'd0,        5'd19, 32'hFFFFFFFF, 1);
        do_op("REMU 9/0",     3'd7, 32'd9,        32'd0,        5'd20, 32'd9,        1);
        do_op("DIV ovf",      3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000, 1);
        do_op("REM ovf",      3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd22, 32'd0,        1);

        // Result held while the consumer stalls; a new request is not taken
        issue(3'd0, 32'd6, 32'd7, 5'h15);
        wait_valid(lat);
        check("hold latency", 64'(lat), 64'd2);
        IN_VALID = 1'b1; FUNCT3 = 3'd0; DATA1 = 32'd1; DATA2 = 32'd1; IN_TAG = 5'd7;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold vld/rdy/tag/result", {OUT_VALID, IN_READY, OUT_TAG, RESULT},
                  {1'b1, 1'b0, 5'h15, 32'd42});
        end
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        check("hold release rdy/vld", {IN_READY, OUT_VALID}, 2'b10);

        // KILL during divide iterations
        issue(3'd5, 32'd1000, 32'd3, 5'd3);
        repeat (10) step();
        check("kill busy before", BUSY, 1'b1);
        KILL = 1'b1;
        step();
        KILL = 1'b0;
        check("kill busy/rdy/vld", {BUSY, IN_READY, OUT_VALID}, 3'b010);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (OUT_VALID) seen = 1'b1;
        end
        check("kill no out_valid", seen, 1'b0);
        do_op("DIVU after kill", 3'd5, 32'd100, 32'd7, 5'd23, 32'd14, 34);

        // KILL beats a same-cycle accept
        IN_VALID = 1'b1; KILL = 1'b1; FUNCT3 = 3'd0; DATA1 = 32'd3; DATA2 = 32'd3; IN_TAG = 5'd9;
        step();
        IN_VALID = 1'b0; KILL = 1'b0;
        check("kill vs accept busy", BUSY, 1'b0);

        // KILL in DONE discards the unread result
        issue(3'd0, 32'd3, 32'd5, 5'd24);
        wait_valid(lat);
        check("kill done latency", 64'(lat), 64'd2);
        KILL = 1'b1;
        step();
        KILL = 1'b0;
        check("kill done vld/rdy", {OUT_VALID, IN_READY}, 2'b01);

        // Asynchronous reset in the middle of a multiply
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'h1F);
        check("mid-mul busy", BUSY, 1'b1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("async reset vld/busy/rdy", {OUT_VALID, BUSY, IN_READY}, 3'b001);
        check("async reset result", RESULT, 32'd0);
        check("async reset tag", OUT_TAG, 5'd0);
        step();
        RESET_N = 1'b1;
        step();
        check("post reset vld/busy", {OUT_VALID, BUSY}, 2'b00);
        do_op("MUL after reset", 3'd0, 32'd3, 32'd3, 5'd25, 32'd9, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
